// File: rtl/signed_bin_to_bcd.sv
// Purpose : converts the 17-bit two's-complement adder result into a sign flag
//           plus packed BCD digits for the seven-segment display path, using an
//           iterative shift-add-3 (double-dabble) engine, one bit per clock.
// Ports   : clk     - system clock, rising edge
//           reset   - asynchronous, active-high; clears all state and outputs
//           start   - conversion request, sampled only while idle
//           bin_in  - two's-complement operand (WIDTH bits)
//           busy    - high while a conversion is in flight (SHIFT, DONE)
//           done    - one-cycle pulse; bcd_out/neg_out valid from this cycle
//           neg_out - 1 when the converted value was negative
//           bcd_out - DIGITS BCD digits, most significant digit in the top nibble
module signed_bin_to_bcd #(
  parameter int unsigned WIDTH  = 17,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  neg_out,
  output logic [DIGITS*4-1:0]   bcd_out
);

  localparam int unsigned BCD_W  = DIGITS * 4;
  localparam int unsigned WORK_W = BCD_W + WIDTH;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;

  // Conversion working registers
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     mag_q, mag_d;
  logic [BCD_W-1:0]     scratch_q, scratch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Registered outputs
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 neg_out_q, neg_out_d;
  logic [BCD_W-1:0]     bcd_out_q, bcd_out_d;

  // Control strobes decoded from the FSM
  logic                 capture_c;
  logic                 shift_c;
  logic                 publish_c;

  // Datapath intermediates
  logic [WIDTH-1:0]     mag_in_c;
  logic [BCD_W-1:0]     adj_c;
  logic [WORK_W-1:0]    work_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // cnt_q == 1 means this edge performs the final shift
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM output decode
  always_comb begin
    capture_c = 1'b0;
    shift_c   = 1'b0;
    publish_c = 1'b0;
    case (state_q)
      S_IDLE:  capture_c = start;
      S_SHIFT: shift_c   = 1'b1;
      S_DONE:  publish_c = 1'b1;
      default: begin
        capture_c = 1'b0;
        shift_c   = 1'b0;
        publish_c = 1'b0;
      end
    endcase
  end

  // Magnitude of the operand; the most negative input maps onto itself as an
  // unsigned value, which is exactly its magnitude
  always_comb begin
    mag_in_c = bin_in;
    if (bin_in[WIDTH-1]) begin
      mag_in_c = WIDTH'(~bin_in + WIDTH'(1));
    end
  end

  // Add 3 to every digit >= 5 so the following shift carries correctly
  always_comb begin
    adj_c = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    work_c = {adj_c, mag_q} << 1;
  end

  // Working-register next values
  always_comb begin
    neg_d     = neg_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    if (capture_c) begin
      neg_d     = bin_in[WIDTH-1];
      mag_d     = mag_in_c;
      scratch_d = '0;
      cnt_d     = CNT_W'(WIDTH);
    end else if (shift_c) begin
      scratch_d = work_c[WORK_W-1:WIDTH];
      mag_d     = work_c[WIDTH-1:0];
      cnt_d     = cnt_q - CNT_W'(1);
    end
  end

  // Output next values; results only change when a conversion completes
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    done_d    = publish_c;
    neg_out_d = neg_out_q;
    bcd_out_d = bcd_out_q;
    if (publish_c) begin
      neg_out_d = neg_q;
      bcd_out_d = scratch_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q     <= 1'b0;
      mag_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      neg_out_q <= 1'b0;
      bcd_out_q <= '0;
    end else begin
      neg_q     <= neg_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      neg_out_q <= neg_out_d;
      bcd_out_q <= bcd_out_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign neg_out = neg_out_q;
  assign bcd_out = bcd_out_q;

endmodule

// File: tb/tb_signed_bin_to_bcd.sv
module tb_signed_bin_to_bcd;

  logic        clk;
  logic        reset;
  logic        start;
  logic [16:0] bin_in;
  logic        busy;
  logic        done;
  logic        neg_out;
  logic [19:0] bcd_out;

  int n_checks;
  int n_fail;

  // Expected {neg, bcd} per accepted conversion
  logic [20:0] sb_q[$];
  logic        prev_done;

  signed_bin_to_bcd #(.WIDTH(17), .DIGITS(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .neg_out (neg_out),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: absolute value then decimal digit split
  function automatic logic [20:0] ref_model(input logic [16:0] v);
    int m;
    logic [19:0] b;
    m = v[16] ? (131072 - int'(v)) : int'(v);
    b = '0;
    for (int i = 0; i < 5; i++) begin
      b[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {v[16], b};
  endfunction

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("done_width", 32'(prev_done), 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [20:0] e;
          e = sb_q.pop_front();
          check("bcd_out", 32'(bcd_out), 32'(e[19:0]));
          check("neg_out", 32'(neg_out), 32'(e[20]));
        end
      end
      prev_done = done;
    end
  end

  // One conversion; optional start spam during edges N+1..N+17
  task automatic convert(input logic [16:0] v, input logic [19:0] eb, input logic en,
                         input logic spam);
    int cyc;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    sb_q.push_back({en, eb});
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = ~v;
    check("busy_after_start", 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 40) begin
      if (spam && cyc < 17) begin
        start  = 1'b1;
        bin_in = 17'(v + 17'(cyc + 1));
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check("latency", 32'(cyc), 32'd18);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [16:0] v;
    logic [19:0] b;
    logic        n;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [20:0] r;
    n_checks  = 0;
    n_fail    = 0;
    prev_done = 1'b0;
    reset     = 1'b1;
    start     = 1'b0;
    bin_in    = '0;

    vecs.push_back('{17'h00000, 20'h00000, 1'b0});
    vecs.push_back('{17'h03039, 20'h12345, 1'b0});
    vecs.push_back('{17'h0FFFF, 20'h65535, 1'b0});
    vecs.push_back('{17'h1FFFF, 20'h00001, 1'b1});
    vecs.push_back('{17'h10000, 20'h65536, 1'b1});
    vecs.push_back('{17'h00001, 20'h00001, 1'b0});
    vecs.push_back('{17'h0270F, 20'h09999, 1'b0});
    vecs.push_back('{17'h1CFC7, 20'h12345, 1'b1});
    vecs.push_back('{17'h1FFF6, 20'h00010, 1'b1});
    vecs.push_back('{17'h00063, 20'h00099, 1'b0});
    vecs.push_back('{17'h00005, 20'h00005, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_neg", 32'(neg_out), 32'd0);
    check("reset_bcd", 32'(bcd_out), 32'd0);
    // Start held across reset release is lost
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("start_during_reset_busy", 32'(busy), 32'd0);

    foreach (vecs[i]) begin
      convert(vecs[i].v, vecs[i].b, vecs[i].n, 1'b0);
    end

    // Extra start requests while busy are ignored
    convert(17'h03039, 20'h12345, 1'b0, 1'b1);
    check("hold_after_done", 32'(bcd_out), 32'h12345);

    // Reset mid-conversion: no done, outputs cleared
    @(negedge clk);
    bin_in = 17'h03039;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd_out), 32'd0);
    check("abort_neg", 32'(neg_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    check("no_done_after_abort", 32'(sb_q.size()), 32'd0);
    convert(17'h03039, 20'h12345, 1'b0, 1'b0);

    // Random operands against the reference model
    for (int k = 0; k < 40; k++) begin
      logic [16:0] v;
      v = 17'($urandom_range(0, 131071));
      r = ref_model(v);
      convert(v, r[19:0], r[20], 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
